// File: rtl/square_iterative_pkg.sv
// Shared arithmetic package: default operand/result widths and the
// state encoding used by the iterative root/square blocks.
package square_iterative_pkg;

    localparam int unsigned DefaultWidthInput  = 8;
    localparam int unsigned DefaultWidthOutput = 2 * DefaultWidthInput;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } sq_state_e;

endpackage

// File: rtl/square_iterative.sv
// Iterative unsigned squarer: one shift-and-add step per operand bit, LSB first,
// with a valid/ready handshake on both the operand and the result side.
module square_iterative
    import square_iterative_pkg::*;
#(
    parameter int unsigned WIDTH_INPUT  = DefaultWidthInput,
    parameter int unsigned WIDTH_OUTPUT = 2 * WIDTH_INPUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [WIDTH_INPUT-1:0]  root,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [WIDTH_OUTPUT-1:0] square
);

    localparam int unsigned CntW = $clog2(WIDTH_INPUT + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH_INPUT - 1);

    sq_state_e               state_q, state_d;
    logic [WIDTH_INPUT-1:0]  op_q;
    logic [WIDTH_OUTPUT-1:0] acc_q;
    logic [CntW-1:0]         cnt_q;

    logic                    bit_k;
    logic [WIDTH_OUTPUT-1:0] addend;

    // Mask-and-reduce avoids indexing op_q with a counter wider than its index.
    assign bit_k  = |(op_q & (WIDTH_INPUT'(1) << cnt_q));
    assign addend = WIDTH_OUTPUT'(op_q) << cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (valid_in) state_d = StBusy;
            StBusy:  if (cnt_q == LastBit) state_d = StDone;
            StDone:  if (ready_out) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_in  = (state_q == StIdle);
        valid_out = (state_q == StDone);
        square    = acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == StIdle && valid_in) begin
            op_q  <= root;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == StBusy) begin
            if (bit_k) acc_q <= acc_q + addend;
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: tb/tb_square_iterative.sv
// Directed bench for square_iterative (WIDTH_INPUT=8): vector table plus
// hand-written sequences for handshake, reset and sweep corner cases.
module tb_square_iterative;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        ready_in;
    logic [7:0]  root;
    logic        valid_out;
    logic        ready_out;
    logic [15:0] square;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;
    bit seen_9801 = 1'b0;

    typedef struct {
        logic [7:0]  r;
        int          stall;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    square_iterative #(
        .WIDTH_INPUT (8),
        .WIDTH_OUTPUT(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .root     (root),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .square   (square)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && valid_in && ready_in) acc_cnt <= acc_cnt + 1;
        if (valid_out && square == 16'd9801) seen_9801 <= 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; the result is held for 'stall' DONE cycles first.
    task automatic run_op(input logic [7:0] r, input int stall, input logic [15:0] exp);
        int lat;
        check("ready_in_idle", ready_in, 1);
        valid_in  = 1'b1;
        root      = r;
        ready_out = (stall == 0);
        tick();
        valid_in = 1'b0;
        root     = ~r;
        check("busy_ready_in", ready_in, 0);
        lat = 0;
        while (!valid_out && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", lat, 8);
        for (int s = 0; s < stall; s++) begin
            check("held_square", square, exp);
            check("stall_ready_in", ready_in, 0);
            check("stall_valid_out", valid_out, 1);
            tick();
        end
        ready_out = 1'b1;
        check("square", square, exp);
        check("done_valid_out", valid_out, 1);
        tick();
        ready_out = 1'b0;
        check("idle_after_ready_in", ready_in, 1);
        check("idle_after_valid_out", valid_out, 0);
    endtask

    initial begin
        int lat;
        int acc_before;
        bit busy_ready_bad;

        vecs[0] = '{r: 8'd255, stall: 0, exp: 16'd65025};
        vecs[1] = '{r: 8'd0,   stall: 0, exp: 16'd0};
        vecs[2] = '{r: 8'd1,   stall: 0, exp: 16'd1};
        vecs[3] = '{r: 8'd16,  stall: 0, exp: 16'd256};
        vecs[4] = '{r: 8'd200, stall: 5, exp: 16'd40000};
        vecs[5] = '{r: 8'd3,   stall: 1, exp: 16'd9};
        vecs[6] = '{r: 8'd128, stall: 2, exp: 16'd16384};
        vecs[7] = '{r: 8'd170, stall: 0, exp: 16'd28900};

        rst = 1'b1; valid_in = 1'b0; ready_out = 1'b0; root = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_ready_in", ready_in, 1);
        check("reset_valid_out", valid_out, 0);
        check("reset_square", square, 0);

        foreach (vecs[i]) run_op(vecs[i].r, vecs[i].stall, vecs[i].exp);

        // valid_in held high with root toggling during BUSY: single acceptance.
        acc_before = acc_cnt;
        busy_ready_bad = 1'b0;
        valid_in = 1'b1;
        root = 8'd77;
        ready_out = 1'b0;
        tick();
        lat = 0;
        while (!valid_out && lat < 20) begin
            if (ready_in) busy_ready_bad = 1'b1;
            root = 8'($urandom);
            tick();
            lat++;
        end
        valid_in = 1'b0;
        check("hold_valid_latency", lat, 8);
        check("hold_valid_ready_in", busy_ready_bad, 0);
        check("hold_valid_square", square, 16'd5929);
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        check("hold_valid_accepts", acc_cnt - acc_before, 1);

        // Reset three cycles into a root=99 operation discards it.
        valid_in = 1'b1;
        root = 8'd99;
        ready_out = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midbusy_rst_valid_out", valid_out, 0);
        check("midbusy_rst_ready_in", ready_in, 1);
        check("midbusy_rst_square", square, 0);
        for (int i = 0; i < 15; i++) tick();
        check("no_9801_emitted", seen_9801, 0);
        check("midbusy_rst_still_idle", ready_in, 1);

        // Reset wins over a same-cycle handshake.
        rst = 1'b1;
        valid_in = 1'b1;
        root = 8'd42;
        tick();
        rst = 1'b0;
        valid_in = 1'b0;
        check("rst_vs_accept_ready_in", ready_in, 1);
        check("rst_vs_accept_square", square, 0);

        // Reset while the result is held in DONE.
        valid_in = 1'b1;
        root = 8'd9;
        ready_out = 1'b0;
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("middone_valid_out", valid_out, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("middone_rst_valid_out", valid_out, 0);
        check("middone_rst_ready_in", ready_in, 1);

        for (int r = 0; r < 256; r++) begin
            run_op(8'(r), int'($urandom_range(0, 2)), 16'(r * r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
